// File: rtl/bure_stage_mem.sv
// bure_stage_mem: memory-access stage issuing loads/stores over a req/gnt/rvalid bus.
module bure_stage_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  i_clk,
  input  logic                  i_rstn,
  input  logic                  i_ex_valid,
  output logic                  o_ex_ready,
  input  logic [DATA_WIDTH-1:0] i_ex_alu_data,
  input  logic [DATA_WIDTH-1:0] i_ex_rs2_data,
  input  logic [2:0]            i_ex_funct3,
  input  logic                  i_ex_is_load,
  input  logic                  i_ex_is_store,
  input  logic [4:0]            i_ex_rd_addr,
  output logic                  o_dmem_req,
  output logic                  o_dmem_we,
  output logic [ADDR_WIDTH-1:0] o_dmem_addr,
  output logic [DATA_WIDTH-1:0] o_dmem_wdata,
  output logic [3:0]            o_dmem_be,
  input  logic                  i_dmem_gnt,
  input  logic                  i_dmem_rvalid,
  input  logic [DATA_WIDTH-1:0] i_dmem_rdata,
  output logic                  o_mem_valid,
  output logic [DATA_WIDTH-1:0] o_mem_data,
  output logic [4:0]            o_mem_rd_addr,
  output logic                  o_mem_rd_we,
  output logic                  o_mem_misaligned
);
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_t;
  state_t state, state_nxt;
  logic [4:0] rd_q;
  logic [2:0] f3_q;
  logic [1:0] lo_q;
  logic store_q, is_mem, is_b, is_h, mis, acc;
  logic [3:0] be_c;
  logic [DATA_WIDTH-1:0] wdata_c, ld_c, ld_sh;
  logic [15:0] ld_h;
  // funct3[1:0] alone picks the size; every undefined encoding falls to word
  always_comb begin
    is_mem = i_ex_is_load | i_ex_is_store;
    is_b = i_ex_funct3[1:0] == 2'b00;
    is_h = i_ex_funct3[1:0] == 2'b01;
    mis = is_h ? i_ex_alu_data[0] : !is_b && (i_ex_alu_data[1:0] != 2'b00);
    be_c = is_b ? 4'b0001 << i_ex_alu_data[1:0] : is_h ? (i_ex_alu_data[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    wdata_c = is_b ? {4{i_ex_rs2_data[7:0]}} : is_h ? {2{i_ex_rs2_data[15:0]}} : i_ex_rs2_data;
    acc = state == IDLE && i_ex_valid;
  end
  always_comb begin
    ld_sh = i_dmem_rdata >> {lo_q, 3'b000};
    ld_h = lo_q[1] ? i_dmem_rdata[31:16] : i_dmem_rdata[15:0];
    ld_c = f3_q[1:0] == 2'b00 ? {{24{!f3_q[2] & ld_sh[7]}}, ld_sh[7:0]}
         : f3_q[1:0] == 2'b01 ? {{16{!f3_q[2] & ld_h[15]}}, ld_h}
         : i_dmem_rdata;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) state <= IDLE;
    else state <= state_nxt;
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: state_nxt = acc && is_mem && !mis ? REQ : IDLE;
      REQ:  state_nxt = i_dmem_gnt ? (store_q ? IDLE : WAIT) : REQ;
      WAIT: state_nxt = i_dmem_rvalid ? IDLE : WAIT;
      default: state_nxt = IDLE;
    endcase
  end
  always_comb begin
    o_ex_ready = state == IDLE;
    o_dmem_req = state == REQ;
    o_dmem_we = state == REQ && store_q;
  end
  always_ff @(posedge i_clk or negedge i_rstn)
    if (!i_rstn) begin
      rd_q <= '0;
      f3_q <= '0;
      lo_q <= '0;
      store_q <= 1'b0;
      o_dmem_addr <= '0;
      o_dmem_wdata <= '0;
      o_dmem_be <= '0;
      o_mem_valid <= 1'b0;
      o_mem_data <= '0;
      o_mem_rd_addr <= '0;
      o_mem_rd_we <= 1'b0;
      o_mem_misaligned <= 1'b0;
    end else begin
      o_mem_valid <= 1'b0;
      o_mem_misaligned <= 1'b0;
      if (acc) begin
        rd_q <= i_ex_rd_addr;
        f3_q <= i_ex_funct3;
        lo_q <= i_ex_alu_data[1:0];
        store_q <= i_ex_is_store;
        o_dmem_addr <= {i_ex_alu_data[ADDR_WIDTH-1:2], 2'b00};
        o_dmem_wdata <= wdata_c;
        o_dmem_be <= be_c;
        if (!is_mem || mis) begin
          o_mem_valid <= 1'b1;
          o_mem_misaligned <= is_mem;
          o_mem_data <= is_mem ? '0 : i_ex_alu_data;
          o_mem_rd_addr <= i_ex_rd_addr;
          o_mem_rd_we <= !is_mem && i_ex_rd_addr != 5'd0;
        end
      end
      if (state == REQ && i_dmem_gnt && store_q) begin
        o_mem_valid <= 1'b1;
        o_mem_rd_addr <= rd_q;
        o_mem_rd_we <= 1'b0;
      end
      if (state == WAIT && i_dmem_rvalid) begin
        o_mem_valid <= 1'b1;
        o_mem_data <= ld_c;
        o_mem_rd_addr <= rd_q;
        o_mem_rd_we <= rd_q != 5'd0;
      end
    end
endmodule

// File: tb/tb_bure_stage_mem.sv
// tb_bure_stage_mem: directed and randomized checks of bure_stage_mem against an arithmetic model.
module tb_bure_stage_mem;
  logic clk = 1'b0, rstn = 1'b0;
  logic ex_valid = 1'b0, ex_ready;
  logic [31:0] alu = '0, rs2 = '0;
  logic [2:0] f3 = '0;
  logic is_ld = 1'b0, is_st = 1'b0;
  logic [4:0] rd = '0;
  logic dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0] dmem_be;
  logic gnt = 1'b0, rvalid = 1'b0;
  logic [31:0] rdata = '0;
  logic mem_valid, mem_rd_we, mem_mis;
  logic [31:0] mem_data;
  logic [4:0] mem_rd;
  int errs = 0, checks = 0;
  logic [31:0] last = '0;

  bure_stage_mem dut (
    .i_clk(clk), .i_rstn(rstn), .i_ex_valid(ex_valid), .o_ex_ready(ex_ready),
    .i_ex_alu_data(alu), .i_ex_rs2_data(rs2), .i_ex_funct3(f3),
    .i_ex_is_load(is_ld), .i_ex_is_store(is_st), .i_ex_rd_addr(rd),
    .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
    .o_dmem_wdata(dmem_wdata), .o_dmem_be(dmem_be), .i_dmem_gnt(gnt),
    .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata), .o_mem_valid(mem_valid),
    .o_mem_data(mem_data), .o_mem_rd_addr(mem_rd), .o_mem_rd_we(mem_rd_we),
    .o_mem_misaligned(mem_mis)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic int nbytes(input logic [2:0] f);
    if (f == 3'd0 || f == 3'd4) return 1;
    if (f == 3'd1 || f == 3'd5) return 2;
    return 4;
  endfunction

  function automatic logic [3:0] exp_be(input logic [31:0] a, input logic [2:0] f);
    int n = nbytes(f);
    return 4'(((1 << n) - 1) << (a % 4));
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [31:0] d, input logic [2:0] f);
    int n = nbytes(f);
    if (n == 1) return 32'(d[7:0] * 32'h01010101);
    if (n == 2) return 32'(d[15:0] * 32'h00010001);
    return d;
  endfunction

  function automatic logic [31:0] exp_load(input logic [31:0] d, input logic [31:0] a, input logic [2:0] f);
    int n = nbytes(f);
    longint v = (longint'(d) >> (8 * (a % 4))) & ((64'd1 << (8 * n)) - 1);
    if (n < 4 && f < 3'd4 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
    return v[31:0];
  endfunction

  // one op from an idle stage; gd = wait cycles before gnt, rvd = extra WAIT cycles before rvalid
  task automatic run_op(input logic [31:0] a, input logic [31:0] d, input logic [2:0] f,
                        input logic ld, input logic st, input logic [4:0] r,
                        input int gd, input int rvd, input logic [31:0] rd_data);
    logic mem, mis;
    mem = ld | st;
    mis = mem && (a % nbytes(f)) != 0;
    @(negedge clk);
    check("ready_idle", {31'd0, ex_ready}, 1);
    alu = a; rs2 = d; f3 = f; is_ld = ld; is_st = st; rd = r; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0;
    if (!mem || mis) begin
      check("pulse_valid", {31'd0, mem_valid}, 1);
      check("pulse_mis", {31'd0, mem_mis}, {31'd0, mis});
      check("pulse_rd_we", {31'd0, mem_rd_we}, {31'd0, !mis && r != 0});
      check("pulse_data", mem_data, mis ? 32'd0 : a);
      check("no_req", {31'd0, dmem_req}, 0);
      if (!mis) check("pulse_rd", {27'd0, mem_rd}, {27'd0, r});
      last = mis ? 32'd0 : a;
    end else begin
      for (int i = 0; i <= gd; i++) begin
        check("req", {31'd0, dmem_req}, 1);
        check("addr", dmem_addr, {a[31:2], 2'b00});
        check("be", {28'd0, dmem_be}, {28'd0, exp_be(a, f)});
        check("we", {31'd0, dmem_we}, {31'd0, st});
        if (st) check("wdata", dmem_wdata, exp_wdata(d, f));
        check("busy_ready", {31'd0, ex_ready}, 0);
        check("early_valid", {31'd0, mem_valid}, 0);
        if (i == gd) gnt = 1'b1;
        @(negedge clk);
        gnt = 1'b0;
      end
      if (st) begin
        check("st_valid", {31'd0, mem_valid}, 1);
        check("st_rd_we", {31'd0, mem_rd_we}, 0);
        check("st_mis", {31'd0, mem_mis}, 0);
      end else begin
        for (int i = 0; i <= rvd; i++) begin
          check("wait_req", {31'd0, dmem_req}, 0);
          check("wait_valid", {31'd0, mem_valid}, 0);
          check("wait_ready", {31'd0, ex_ready}, 0);
          if (i == rvd) begin rvalid = 1'b1; rdata = rd_data; end
          @(negedge clk);
          rvalid = 1'b0;
        end
        last = exp_load(rd_data, a, f);
        check("ld_valid", {31'd0, mem_valid}, 1);
        check("ld_data", mem_data, last);
        check("ld_rd_we", {31'd0, mem_rd_we}, {31'd0, r != 0});
        check("ld_rd", {27'd0, mem_rd}, {27'd0, r});
        check("ld_mis", {31'd0, mem_mis}, 0);
      end
    end
    @(negedge clk);
    check("pulse_end", {31'd0, mem_valid}, 0);
    check("mis_end", {31'd0, mem_mis}, 0);
    if (!st || mis) check("data_hold", mem_data, last);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", {31'd0, ex_ready}, 1);
    check("rst_req", {31'd0, dmem_req}, 0);
    check("rst_valid", {31'd0, mem_valid}, 0);
    check("rst_data", mem_data, 0);
    check("rst_be", {28'd0, dmem_be}, 0);
    rstn = 1'b1;

    // back-to-back ALU ops
    @(negedge clk);
    alu = 32'h1234; rd = 5'd5; is_ld = 1'b0; is_st = 1'b0; ex_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("b2b_valid", {31'd0, mem_valid}, 1);
      check("b2b_data", mem_data, 32'h1234);
      check("b2b_rd_we", {31'd0, mem_rd_we}, 1);
      check("b2b_ready", {31'd0, ex_ready}, 1);
    end
    ex_valid = 1'b0;
    @(negedge clk);
    check("b2b_end", {31'd0, mem_valid}, 0);
    last = 32'h1234;

    run_op(32'h1003, 32'hAABBCCDD, 3'd0, 1'b0, 1'b1, 5'd7, 2, 0, 32'd0);
    run_op(32'h2002, 32'd0, 3'd0, 1'b1, 1'b0, 5'd8, 0, 1, 32'h00800000);
    check("lb_dir", mem_data, 32'hFFFFFF80);
    run_op(32'h2002, 32'd0, 3'd4, 1'b1, 1'b0, 5'd8, 0, 1, 32'h00800000);
    check("lbu_dir", mem_data, 32'h00000080);
    run_op(32'h3002, 32'd0, 3'd1, 1'b1, 1'b0, 5'd9, 1, 0, 32'h80010000);
    check("lh_dir", mem_data, 32'hFFFF8001);
    run_op(32'h4002, 32'd0, 3'd2, 1'b1, 1'b0, 5'd10, 0, 0, 32'd0);
    run_op(32'h4004, 32'h0BADF00D, 3'd2, 1'b0, 1'b1, 5'd0, 0, 0, 32'd0);
    run_op(32'h4004, 32'd0, 3'd2, 1'b1, 1'b0, 5'd0, 0, 0, 32'h12345678);

    // reset while a load sits in WAIT
    @(negedge clk);
    alu = 32'h5000; f3 = 3'd2; is_ld = 1'b1; is_st = 1'b0; rd = 5'd3; ex_valid = 1'b1;
    @(negedge clk);
    ex_valid = 1'b0; gnt = 1'b1;
    @(negedge clk);
    gnt = 1'b0;
    check("wait_pre_rst", {31'd0, ex_ready}, 0);
    #1 rstn = 1'b0;
    #1;
    check("arst_req", {31'd0, dmem_req}, 0);
    check("arst_ready", {31'd0, ex_ready}, 1);
    check("arst_valid", {31'd0, mem_valid}, 0);
    @(negedge clk);
    rstn = 1'b1;
    rvalid = 1'b1; rdata = 32'hCAFEBABE;
    @(negedge clk);
    rvalid = 1'b0;
    check("late_rvalid", {31'd0, mem_valid}, 0);
    check("late_ready", {31'd0, ex_ready}, 1);
    last = 32'd0;

    for (int k = 0; k < 40; k++) begin
      int kind = $urandom_range(0, 2);
      run_op($urandom, $urandom, 3'($urandom_range(0, 7)), kind == 1, kind == 2,
             5'($urandom_range(0, 31)), $urandom_range(0, 3), $urandom_range(0, 2), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/bure_stage_mem.md
Name: bure_stage_mem

Overview:
Memory-access stage directly downstream of the execute stage.
- Consumes the execute result: ALU result / effective address, store data, op info.
- Performs loads and stores over a req/gnt/rvalid data-memory bus, with byte-enable generation and load sign/zero extension.
- Presents a one-cycle result pulse to writeback and stalls execute via a ready signal while a bus transaction is in flight.

Parameters:
DATA_WIDTH, 32, datapath width; only 32 is supported (byte-lane logic is RV32-specific).
ADDR_WIDTH, 32, data-memory address width; the low ADDR_WIDTH bits of the ALU result are used.

Ports:
i_clk  in  1  clock
i_rstn  in  1  reset; asynchronous, active-low
i_ex_valid  in  1  execute stage presents an op this cycle
o_ex_ready  out  1  stage can accept an op this cycle
i_ex_alu_data  in  DATA_WIDTH  ALU result, or effective address for load/store
i_ex_rs2_data  in  DATA_WIDTH  store data
i_ex_funct3  in  3  load/store size and sign
i_ex_is_load  in  1  op is a load
i_ex_is_store  in  1  op is a store
i_ex_rd_addr  in  5  destination register
o_dmem_req  out  1  bus request
o_dmem_we  out  1  1 = write
o_dmem_addr  out  ADDR_WIDTH  word-aligned address (bits [1:0] = 0)
o_dmem_wdata  out  DATA_WIDTH  lane-replicated store data
o_dmem_be  out  4  byte enables
i_dmem_gnt  in  1  request accepted
i_dmem_rvalid  in  1  read data valid
i_dmem_rdata  in  DATA_WIDTH  read data
o_mem_valid  out  1  one-cycle result pulse to writeback
o_mem_data  out  DATA_WIDTH  result data
o_mem_rd_addr  out  5  destination register
o_mem_rd_we  out  1  writeback enable; 0 for stores, rd=0, and misaligned ops
o_mem_misaligned  out  1  misaligned access flag, valid with o_mem_valid

Behaviour:
- Reset (async, i_rstn low): state=IDLE. All outputs 0 except o_ex_ready=1. An in-flight bus transaction is abandoned; any late gnt/rvalid after reset release is ignored while in IDLE.
- FSM states:
  - IDLE: accept an op when i_ex_valid=1.
  - REQ: o_dmem_req=1 and all bus outputs held stable until i_dmem_gnt=1.
  - WAIT: load waits for i_dmem_rvalid.
- o_ex_ready=1 only in IDLE. The handshake is i_ex_valid && o_ex_ready; inputs are captured in that cycle.
- Non-memory op (is_load=is_store=0): o_mem_valid pulses the next cycle with o_mem_data=alu_data, rd_we=(rd!=0). Latency 1. Back-to-back acceptance every cycle.
- Load/store, aligned: register operands and go to REQ the next cycle.
- Store: on gnt, return to IDLE and pulse o_mem_valid (rd_we=0) in the following cycle. Minimum latency 2.
- Load: on gnt, go to WAIT. On rvalid, pulse o_mem_valid the next cycle with extended data and return to IDLE. Minimum latency 3.
- rvalid in REQ or IDLE is ignored. Bus guarantees rvalid ≥1 cycle after gnt.
- funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU. Any other funct3 on load/store is treated as W.
- Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
  - Misaligned op: no bus request. o_mem_valid pulses next cycle with o_mem_misaligned=1, rd_we=0, data=0.
- Byte enables:
  - B: 1<<addr[1:0].
  - H: 0011 if addr[1]=0, else 1100.
  - W: 1111.
- wdata:
  - B: byte replicated ×4.
  - H: half replicated ×2.
  - W: as-is.
- Load extract: select lane by captured addr[1:0]. B/H sign-extend; BU/HU zero-extend.
- o_mem_* outputs are registered. They hold their last value when o_mem_valid=0, except o_mem_valid and o_mem_misaligned, which are 0 outside the pulse.
- Simultaneous gnt and rvalid in the same cycle: rvalid is ignored (not in WAIT).
- o_dmem_we=1 only for stores in REQ; 0 otherwise.

Test Plan:
- Reset low mid-load (state WAIT) → next cycle o_dmem_req=0, o_ex_ready=1, o_mem_valid=0; an rvalid after release produces no o_mem_valid.
- ALU op alu_data=0x1234, rd=5, valid 3 consecutive cycles → o_mem_valid pulses each following cycle, data 0x1234, rd_we=1, o_ex_ready stays 1.
- SB addr=0x1003, rs2=0xAABBCCDD, gnt delayed 2 cycles → req held 3 cycles with addr=0x1000, be=1000, wdata=0xDDDDDDDD, we=1; o_mem_valid 1 cycle after gnt, rd_we=0.
- LB addr=0x2002, rdata=0x00800000, rvalid 2 cycles after gnt → o_mem_data=0xFFFFFF80; same stimulus as LBU → 0x00000080.
- LH addr=0x3002, rdata=0x80010000 → data 0xFFFF8001, be=1100.
- LW addr=0x4002 (misaligned) → no o_dmem_req ever; next cycle o_mem_valid=1, o_mem_misaligned=1, rd_we=0.
